fetch_unit: RTL

- Instruction fetch stage, directly upstream of the combinational instruction memory.
- Owns the program counter and drives the memory address. Captures the returned word into a registered IF/ID output with valid/ready handshake.
- Handles pipeline redirects (branch/jump/trap), downstream backpressure, and misaligned redirect targets.
- Keeps a retired-fetch counter for performance monitoring.

---
 rtl/fetch_unit.sv | 107 ++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the combinational instruction
// memory and registers the returned word into a valid/ready IF/ID bundle.
module fetch_unit #(
  parameter int                 XLEN         = 32,
  parameter int                 INST_WIDTH   = 32,
  parameter logic [XLEN-1:0]    RESET_VECTOR = '0
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  output logic [XLEN-1:0]       o_imem_addr,
  input  logic [INST_WIDTH-1:0] i_imem_inst,
  input  logic                  i_redirect,
  input  logic [XLEN-1:0]       i_redirect_pc,
  input  logic                  i_ready,
  output logic                  o_valid,
  output logic [INST_WIDTH-1:0] o_inst,
  output logic [XLEN-1:0]       o_pc,
  output logic [XLEN-1:0]       o_pc_plus4,
  output logic                  o_fault,
  output logic [31:0]           o_fetch_count,
  output logic [1:0]            o_state
);

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  state_t          state;
  state_t          next_state;
  logic [XLEN-1:0] pc;
  logic            issued;
  logic            load;
  logic            accept;

  // Handshake: a bundle transfers on any cycle with o_valid && i_ready; while
  // o_valid && !i_ready the bundle and pc hold. A redirect flushes the held
  // bundle regardless, but a transfer in that same cycle still counts.
  assign load        = !o_valid || i_ready;
  assign accept      = o_valid && i_ready;
  assign o_imem_addr = pc;
  assign o_state     = state;

  always_comb begin
    next_state = state;
    if (i_redirect) begin
      next_state = (i_redirect_pc[1:0] == 2'b00) ? S_RUN : S_FAULT;
    end else if (state == S_BOOT) begin
      next_state = S_RUN;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= S_BOOT;
      pc            <= RESET_VECTOR;
      issued        <= 1'b0;
      o_valid       <= 1'b0;
      o_inst        <= '0;
      o_pc          <= '0;
      o_pc_plus4    <= '0;
      o_fault       <= 1'b0;
      o_fetch_count <= '0;
    end else begin
      state <= next_state;
      if (accept && !o_fault) begin
        o_fetch_count <= o_fetch_count + 32'd1;
      end
      if (i_redirect) begin
        o_valid <= 1'b0;
        pc      <= i_redirect_pc;
        issued  <= 1'b0;
      end else begin
        case (state)
          S_RUN: begin
            if (load) begin
              o_inst     <= i_imem_inst;
              o_pc       <= pc;
              o_pc_plus4 <= pc + XLEN'(4);
              o_fault    <= 1'b0;
              o_valid    <= 1'b1;
              pc         <= pc + XLEN'(4);
            end
          end
          S_FAULT: begin
            // A misaligned target yields exactly one fault bundle, then silence.
            if (load) begin
              if (!issued) begin
                o_valid    <= 1'b1;
                o_fault    <= 1'b1;
                o_pc       <= pc;
                o_pc_plus4 <= pc + XLEN'(4);
                o_inst     <= '0;
                issued     <= 1'b1;
              end else begin
                o_valid <= 1'b0;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
